// File: rtl/posit_sign_unpack_if.sv
// Precision-mode package and the stream interface of the posit sign-unpack stage.
// Carries the input word handshake and the unpacked output word with its lane flags.
package pe_pkg;
   localparam int PRECISION_CONFIG_L = 2;
   localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
   localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
   localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;
endpackage

interface posit_sign_unpack_if;
   import pe_pkg::*;

   // Handshake: a word moves on a rising clk edge where vld and rdy are both 1;
   // a producer holding vld keeps its data stable until that edge.
   logic                          in_vld;
   logic                          in_rdy;
   logic [31:0]                   in_data;
   logic [PRECISION_CONFIG_L-1:0] in_mode;
   logic                          out_vld;
   logic                          out_rdy;
   logic [31:0]                   out_data;
   logic [PRECISION_CONFIG_L-1:0] out_mode;
   logic [3:0]                    out_sign;
   logic [3:0]                    out_zero;
   logic [3:0]                    out_nar;

   modport master (
      output in_vld, in_data, in_mode, out_rdy,
      input  in_rdy, out_vld, out_data, out_mode, out_sign, out_zero, out_nar
   );

   modport slave (
      input  in_vld, in_data, in_mode, out_rdy,
      output in_rdy, out_vld, out_data, out_mode, out_sign, out_zero, out_nar
   );
endinterface

// File: rtl/posit_sign_unpack.sv
// Two-stage elastic pipeline: per-lane zero/NaR detect, sign strip and left-align of posit lanes.
// Optional NaR lane counter enabled by defining POSIT_SIGN_UNPACK_NAR_CNT_EN.
module posit_sign_unpack
   import pe_pkg::*;
#(
   parameter int ES_L_32 = 6,
   parameter int ES_L_16 = 4,
   parameter int ES_L_8  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   posit_sign_unpack_if.slave   bus
`ifdef POSIT_SIGN_UNPACK_NAR_CNT_EN
   ,
   input  logic                 nar_cnt_clr,
   output logic [15:0]          nar_cnt
`endif
);

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  sign;
      logic [3:0]  zero;
      logic [3:0]  nar;
   } unpack_t;

   // Zero and NaR lanes both emit 0; other lanes emit |x| with the sign slot shifted out.
   function automatic void lane32(input logic [31:0] x, output logic [31:0] d,
                                  output logic s, output logic z, output logic n);
      logic [31:0] m;
      z = (x == 32'h0000_0000);
      n = (x == 32'h8000_0000);
      s = x[31] & ~n;
      m = x[31] ? (32'h0 - x) : x;
      d = (z | n) ? 32'h0 : {m[30:0], 1'b0};
   endfunction

   function automatic void lane16(input logic [15:0] x, output logic [15:0] d,
                                  output logic s, output logic z, output logic n);
      logic [15:0] m;
      z = (x == 16'h0000);
      n = (x == 16'h8000);
      s = x[15] & ~n;
      m = x[15] ? (16'h0 - x) : x;
      d = (z | n) ? 16'h0 : {m[14:0], 1'b0};
   endfunction

   function automatic void lane8(input logic [7:0] x, output logic [7:0] d,
                                 output logic s, output logic z, output logic n);
      logic [7:0] m;
      z = (x == 8'h00);
      n = (x == 8'h80);
      s = x[7] & ~n;
      m = x[7] ? (8'h0 - x) : x;
      d = (z | n) ? 8'h0 : {m[6:0], 1'b0};
   endfunction

   // Stage 1: raw word
   logic                          s1_vld_q,  s1_vld_d;
   logic [31:0]                   s1_data_q, s1_data_d;
   logic [PRECISION_CONFIG_L-1:0] s1_mode_q, s1_mode_d;

   // Stage 2: unpacked word, drives the outputs directly
   logic                          out_vld_q,  out_vld_d;
   unpack_t                       out_res_q,  out_res_d;
   logic [PRECISION_CONFIG_L-1:0] out_mode_q, out_mode_d;

   logic    s1_en;
   logic    s2_en;
   unpack_t s1_res;

   always_comb begin
      s2_en = ~out_vld_q | bus.out_rdy;
      s1_en = ~s1_vld_q | s2_en;
   end

   always_comb begin : unpack_comb
      logic [31:0] d32;
      logic [15:0] d16;
      logic [7:0]  d8;
      logic        s, z, n;
      s1_res = '0;
      d32    = '0;
      d16    = '0;
      d8     = '0;
      s      = 1'b0;
      z      = 1'b0;
      n      = 1'b0;
      case (s1_mode_q)
         PRECISION_CONFIG_16B: begin
            for (int i = 0; i < 2; i++) begin
               lane16(s1_data_q[16*i +: 16], d16, s, z, n);
               s1_res.data[16*i +: 16] = d16;
               s1_res.sign[i]          = s;
               s1_res.zero[i]          = z;
               s1_res.nar[i]           = n;
            end
         end
         PRECISION_CONFIG_8B: begin
            for (int i = 0; i < 4; i++) begin
               lane8(s1_data_q[8*i +: 8], d8, s, z, n);
               s1_res.data[8*i +: 8] = d8;
               s1_res.sign[i]        = s;
               s1_res.zero[i]        = z;
               s1_res.nar[i]         = n;
            end
         end
         // 32B, and any illegal encoding, run as a single 32-bit lane
         default: begin
            lane32(s1_data_q, d32, s, z, n);
            s1_res.data    = d32;
            s1_res.sign[0] = s;
            s1_res.zero[0] = z;
            s1_res.nar[0]  = n;
         end
      endcase
   end

   always_comb begin
      s1_vld_d   = s1_vld_q;
      s1_data_d  = s1_data_q;
      s1_mode_d  = s1_mode_q;
      out_vld_d  = out_vld_q;
      out_res_d  = out_res_q;
      out_mode_d = out_mode_q;
      if (s1_en) begin
         s1_vld_d = bus.in_vld;
      end
      if (bus.in_vld && s1_en) begin
         s1_data_d = bus.in_data;
         s1_mode_d = bus.in_mode;
      end
      if (s2_en) begin
         out_vld_d = s1_vld_q;
      end
      if (s1_vld_q && s2_en) begin
         out_res_d  = s1_res;
         out_mode_d = s1_mode_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q   <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= PRECISION_CONFIG_32B;
         out_vld_q  <= 1'b0;
         out_res_q  <= '0;
         out_mode_q <= PRECISION_CONFIG_32B;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         out_vld_q  <= out_vld_d;
         out_res_q  <= out_res_d;
         out_mode_q <= out_mode_d;
      end
   end

   assign bus.in_rdy   = s1_en;
   assign bus.out_vld  = out_vld_q;
   assign bus.out_data = out_res_q.data;
   assign bus.out_mode = out_mode_q;
   assign bus.out_sign = out_res_q.sign;
   assign bus.out_zero = out_res_q.zero;
   assign bus.out_nar  = out_res_q.nar;

`ifdef POSIT_SIGN_UNPACK_NAR_CNT_EN
   logic [15:0] nar_cnt_q, nar_cnt_d;
   logic [2:0]  nar_inc;
   logic [16:0] nar_sum;

   always_comb begin
      nar_inc = '0;
      for (int i = 0; i < 4; i++) begin
         nar_inc = nar_inc + {2'b00, out_res_q.nar[i]};
      end
      nar_sum   = {1'b0, nar_cnt_q} + {14'h0, nar_inc};
      nar_cnt_d = nar_cnt_q;
      if (nar_cnt_clr) begin
         nar_cnt_d = 16'h0000;
      end else if (out_vld_q && bus.out_rdy) begin
         nar_cnt_d = nar_sum[16] ? 16'hFFFF : nar_sum[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nar_cnt_q <= 16'h0000;
      end else begin
         nar_cnt_q <= nar_cnt_d;
      end
   end

   assign nar_cnt = nar_cnt_q;
`endif

   // Field lengths only constrain sanity here; the extractor downstream consumes them.
   a_es_len_ok : assert property (@(posedge clk)
      (ES_L_32 >= 0) && (ES_L_32 < 32) && (ES_L_16 >= 0) && (ES_L_16 < 16) &&
      (ES_L_8 >= 0) && (ES_L_8 < 8));

   a_mode_legal : assert property (@(posedge clk) disable iff (!rst_n)
      (bus.in_vld && bus.in_rdy) |->
      ((bus.in_mode == PRECISION_CONFIG_32B) || (bus.in_mode == PRECISION_CONFIG_16B) ||
       (bus.in_mode == PRECISION_CONFIG_8B)));

endmodule

// File: tb/tb_posit_sign_unpack.sv
// Directed bench for posit_sign_unpack: hand-computed vectors, backpressure, reset and
// (with POSIT_SIGN_UNPACK_NAR_CNT_EN) the saturating NaR counter.
module tb_posit_sign_unpack;
   import pe_pkg::*;

   localparam int EW = 46; // {mode, sign, zero, nar, data}

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   bit   sb_en;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] prev_obs;
   bit            stall_prev;

   posit_sign_unpack_if bus ();

`ifdef POSIT_SIGN_UNPACK_NAR_CNT_EN
   logic        nar_cnt_clr;
   logic [15:0] nar_cnt;
   logic [15:0] exp_cnt;
`endif

   posit_sign_unpack dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus)
`ifdef POSIT_SIGN_UNPACK_NAR_CNT_EN
      ,
      .nar_cnt_clr (nar_cnt_clr),
      .nar_cnt     (nar_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [1:0] m, input logic [3:0] s,
                                        input logic [3:0] z, input logic [3:0] n,
                                        input logic [31:0] d);
      return {m, s, z, n, d};
   endfunction

   function automatic logic [EW-1:0] observe();
      return {bus.out_mode, bus.out_sign, bus.out_zero, bus.out_nar, bus.out_data};
   endfunction

   // driver: inputs change only just after a rising edge; in_rdy is sampled on the falling edge
   task automatic push(input logic [31:0] d, input logic [1:0] m, input logic [EW-1:0] e);
      int n;
      n = 0;
      exp_q.push_back(e);
      bus.in_vld  = 1'b1;
      bus.in_data = d;
      bus.in_mode = m;
      @(negedge clk);
      while (!bus.in_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) check("in_rdy_wait", {63'h0, bus.in_rdy}, 64'h1);
      @(posedge clk);
      #1;
      bus.in_vld = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'h0);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst_n || !sb_en) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) check("hold_stable", 64'(observe()), 64'(prev_obs));
         if (bus.out_vld && bus.out_rdy) begin
            if (exp_q.size() == 0) check("unexpected_out", {63'h0, bus.out_vld}, 64'h0);
            else check("out_word", 64'(observe()), 64'(exp_q.pop_front()));
         end
         stall_prev = bus.out_vld && !bus.out_rdy;
         prev_obs   = observe();
      end
   end

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      sb_en       = 1'b1;
      stall_prev  = 1'b0;
      rst_n       = 1'b0;
      bus.in_vld  = 1'b0;
      bus.in_data = '0;
      bus.in_mode = PRECISION_CONFIG_32B;
      bus.out_rdy = 1'b1;
`ifdef POSIT_SIGN_UNPACK_NAR_CNT_EN
      nar_cnt_clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_out_vld", {63'h0, bus.out_vld}, 64'h0);
      check("rst_outputs", 64'(observe()), 64'h0);
      check("rst_in_rdy", {63'h0, bus.in_rdy}, 64'h1);
`ifdef POSIT_SIGN_UNPACK_NAR_CNT_EN
      check("rst_nar_cnt", {48'h0, nar_cnt}, 64'h0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // first vector with latency check
      push(32'hC000_0000, PRECISION_CONFIG_32B, mk(2'd0, 4'b0001, 4'b0000, 4'b0000, 32'h8000_0000));
      @(negedge clk);
      check("lat_cycle1", {63'h0, bus.out_vld}, 64'h0);
      @(negedge clk);
      check("lat_cycle2", {63'h0, bus.out_vld}, 64'h1);
      @(posedge clk);
      #1;

      // back-to-back directed vectors
      push(32'h8000_0001, PRECISION_CONFIG_16B, mk(2'd1, 4'b0000, 4'b0000, 4'b0010, 32'h0000_0002));
      push(32'hFF00_7F81, PRECISION_CONFIG_8B,  mk(2'd2, 4'b1001, 4'b0100, 4'b0000, 32'h0200_FEFE));
      push(32'h0000_0000, PRECISION_CONFIG_32B, mk(2'd0, 4'b0000, 4'b0001, 4'b0000, 32'h0000_0000));
      push(32'h8000_0000, PRECISION_CONFIG_32B, mk(2'd0, 4'b0000, 4'b0000, 4'b0001, 32'h0000_0000));
      push(32'h0000_0001, PRECISION_CONFIG_32B, mk(2'd0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0002));
      push(32'hFFFF_FFFF, PRECISION_CONFIG_32B, mk(2'd0, 4'b0001, 4'b0000, 4'b0000, 32'h0000_0002));
      push(32'hFFFF_0000, PRECISION_CONFIG_16B, mk(2'd1, 4'b0010, 4'b0001, 4'b0000, 32'h0002_0000));
      push(32'h8000_8000, PRECISION_CONFIG_8B,  mk(2'd2, 4'b0000, 4'b0101, 4'b1010, 32'h0000_0000));
      push(32'h7FFF_8001, PRECISION_CONFIG_16B, mk(2'd1, 4'b0001, 4'b0000, 4'b0000, 32'hFFFE_FFFE));
      push(32'h40C0_017F, PRECISION_CONFIG_8B,  mk(2'd2, 4'b0100, 4'b0000, 4'b0000, 32'h8080_02FE));
      drain();

      // backpressure: two words fill the pipe, then in_rdy must drop
      @(posedge clk);
      #1;
      bus.out_rdy = 1'b0;
      push(32'h0100_0000, PRECISION_CONFIG_32B, mk(2'd0, 4'b0000, 4'b0000, 4'b0000, 32'h0200_0000));
      push(32'h0200_0000, PRECISION_CONFIG_32B, mk(2'd0, 4'b0000, 4'b0000, 4'b0000, 32'h0400_0000));
      @(negedge clk);
      check("bp_in_rdy_low", {63'h0, bus.in_rdy}, 64'h0);
      check("bp_head_word", {32'h0, bus.out_data}, 64'h0200_0000);
      @(posedge clk);
      #1;
      fork
         begin
            push(32'h0300_0000, PRECISION_CONFIG_32B, mk(2'd0, 4'b0000, 4'b0000, 4'b0000, 32'h0600_0000));
            push(32'h0400_0000, PRECISION_CONFIG_32B, mk(2'd0, 4'b0000, 4'b0000, 4'b0000, 32'h0800_0000));
            push(32'h0500_0000, PRECISION_CONFIG_32B, mk(2'd0, 4'b0000, 4'b0000, 4'b0000, 32'h0A00_0000));
         end
         begin
            @(posedge clk);
            #1;
            bus.out_rdy = 1'b1;
         end
      join
      drain();

      // reset with both stages full
      @(posedge clk);
      #1;
      bus.out_rdy = 1'b0;
      push(32'h0000_0003, PRECISION_CONFIG_32B, mk(2'd0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0006));
      push(32'hFF00_7F81, PRECISION_CONFIG_8B,  mk(2'd2, 4'b1001, 4'b0100, 4'b0000, 32'h0200_FEFE));
      @(negedge clk);
      check("pre_rst_full", {62'h0, bus.out_vld, bus.in_rdy}, 64'h2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_vld", {63'h0, bus.out_vld}, 64'h0);
      check("mid_rst_outputs", 64'(observe()), 64'h0);
      check("mid_rst_in_rdy", {63'h0, bus.in_rdy}, 64'h1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_vld", {63'h0, bus.out_vld}, 64'h0);
      end
      @(posedge clk);
      #1;
      push(32'hC000_0000, PRECISION_CONFIG_16B, mk(2'd1, 4'b0010, 4'b0001, 4'b0000, 32'h8000_0000));
      drain();

`ifdef POSIT_SIGN_UNPACK_NAR_CNT_EN
      // NaR counter: run up to saturation, then clear together with a handshake
      sb_en = 1'b0;
      @(posedge clk);
      #1;
      exp_cnt     = nar_cnt;
      check("cnt_start", {48'h0, nar_cnt}, 64'h0);
      bus.in_vld  = 1'b1;
      bus.in_data = 32'h8080_8080;
      bus.in_mode = PRECISION_CONFIG_8B;
      for (int k = 0; k < 16400; k++) begin
         @(negedge clk);
         check("nar_cnt", {48'h0, nar_cnt}, {48'h0, exp_cnt});
         if (bus.out_vld && bus.out_rdy)
            exp_cnt = (exp_cnt > 16'hFFFB) ? 16'hFFFF : exp_cnt + 16'd4;
      end
      check("nar_cnt_sat", {48'h0, nar_cnt}, 64'hFFFF);
      @(posedge clk);
      #1;
      nar_cnt_clr = 1'b1;
      @(negedge clk);
      check("clr_with_hs", {62'h0, bus.out_vld, bus.out_rdy}, 64'h3);
      @(posedge clk);
      #1;
      nar_cnt_clr = 1'b0;
      bus.in_vld  = 1'b0;
      @(negedge clk);
      check("nar_cnt_clr", {48'h0, nar_cnt}, 64'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
